// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter FSM granting one shared, single-owner resource to one
// of N requesters at a time.
//
// Grants are registered and one-hot. A grant is held until its owner drops
// its request. Every change of owner passes through one turnaround cycle
// with no grant. The priority pointer moves past a winner only when the grant
// is issued, never on release.
//
// Optional feature (macro ARB_HOLD_LIMIT_EN): an 8-bit hold counter revokes
// a grant after MAX_HOLD consecutive cycles and pulses preempt for one cycle.
// With the macro undefined no counter is built and preempt is tied low.
//
// Parameters:
//   N        number of requesters (2..16)
//   IDX_W    width of gnt_idx, derived from N (do not override)
//   MAX_HOLD hold limit in cycles (1..255), used only with ARB_HOLD_LIMIT_EN
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester request, held high while ownership is wanted
//   gnt      one-hot grant, all-zero when there is no owner
//   gnt_idx  index of the current owner, 0 when gnt is zero
//   busy     high while a grant is held (OR of gnt)
//   preempt  one-cycle pulse when a grant was revoked by the hold limit
module rr_arbiter_fsm #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             preempt
);

  if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arbiter_fsm: N must be 2..16 and MAX_HOLD 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [N-1:0]     gnt_n;
  logic [IDX_W-1:0] gnt_idx_n;
  logic             busy_n;
  logic             preempt_n;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int unsigned      cand;

  // Rotating priority scan starting at ptr. Once a winner is found later
  // candidates are not consulted, so their values cannot disturb the result.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!win_found) begin
        if (req[cand[IDX_W-1:0]]) begin
          win_found = 1'b1;
          win_idx   = cand[IDX_W-1:0];
        end
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt, hold_n;
`endif

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gnt_n     = gnt;
    gnt_idx_n = gnt_idx;
    busy_n    = busy;
    preempt_n = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_n    = hold_cnt;
`endif
    unique case (state)
      IDLE, TURN: begin
        if (win_found) begin
          state_n   = GRANT;
          gnt_n     = N'(1) << win_idx;
          gnt_idx_n = win_idx;
          busy_n    = 1'b1;
          ptr_n     = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
          hold_n    = '0;
`endif
        end else begin
          state_n   = IDLE;
          gnt_n     = '0;
          gnt_idx_n = '0;
          busy_n    = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          state_n   = TURN;
          gnt_n     = '0;
          gnt_idx_n = '0;
          busy_n    = 1'b0;
        end
`ifdef ARB_HOLD_LIMIT_EN
        // The counter holds the number of completed grant cycles, so the
        // grant is revoked on the edge that would make it reach MAX_HOLD.
        // A simultaneous release takes the branch above, without preempt.
        else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          state_n   = TURN;
          gnt_n     = '0;
          gnt_idx_n = '0;
          busy_n    = 1'b0;
          preempt_n = 1'b1;
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
`endif
      end
      default: begin
        state_n   = IDLE;
        gnt_n     = '0;
        gnt_idx_n = '0;
        busy_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      gnt_idx <= gnt_idx_n;
      busy    <= busy_n;
      preempt <= preempt_n;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_n;
  end
`else
  logic unused_preempt_n;
  assign unused_preempt_n = preempt_n;
`endif

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Testbench for rr_arbiter_fsm (N=4, MAX_HOLD=8).
// A reference model steps once per rising edge and queues the expected
// registered outputs; a monitor on the falling edge pops and compares them
// and also checks the grant invariants. Stimulus is a set of directed
// scenarios followed by randomized request traffic with occasional resets.
module tb_rr_arbiter_fsm;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         busy;
  logic         preempt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_fsm #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   idx;
    logic         busy;
    logic         pre;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req_v);
    end
  endtask

  // Reference model: the owner is -1 when nobody holds the grant. Idle and
  // turnaround behave the same from the outside: the cycle after a release
  // has no owner, and arbitration happens from any no-owner cycle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  task automatic model_step();
    exp_t e;
    int   w;
    bit   pre;
    pre = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner >= 0) begin
      if (req[m_owner] !== 1'b1) m_owner = -1;
`ifdef ARB_HOLD_LIMIT_EN
      else if (m_hold + 1 >= MAX_HOLD) begin
        m_owner = -1;
        pre     = 1'b1;
      end
`endif
      else m_hold++;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N] === 1'b1) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_hold  = 0;
      end
    end
    e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.idx  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.busy = (m_owner >= 0);
    e.pre  = pre;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("gnt",     32'(gnt),     32'(e.gnt));
      check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
      check("busy",    32'(busy),    32'(e.busy));
      check("preempt", 32'(preempt), 32'(e.pre));
      check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv_busy_or", 32'(busy), 32'(|gnt));
      if (gnt != '0) check("inv_idx_match", 32'(gnt[gnt_idx]), 32'd1);
      else           check("inv_idx_zero", 32'(gnt_idx), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    for (int t = 0; t < 10 && gnt == '0; t++) cyc(1);
    check(name, 32'(gnt != '0), 32'd1);
  endtask

  initial begin
    int o;
    int rate;
    // Reset held with all requests pending, then release.
    rst = 1'b1; req = 4'b1111;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    // Round-robin: each owner holds ~2 cycles, releases, re-requests.
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr_wait_grant");
      o = int'(gnt_idx);
      cyc(1);
      req[o] = 1'b0;
      cyc(1);
      req[o] = 1'b1;
    end
    cyc(3);
    // Wrap and skip: grant 2 so ptr=3, then 4'b0101 -> 0, then -> 2.
    rst = 1'b1; req = '0; cyc(1); rst = 1'b0;
    req = 4'b0100; cyc(2);
    req = 4'b0000; cyc(2);
    req = 4'b0101; cyc(3);
    req = 4'b0100; cyc(3);
    req = 4'b0101; cyc(2);
    req = 4'b0000; cyc(2);
    // Single requester re-win after one turnaround.
    req = 4'b0100; cyc(3);
    req = 4'b0000; cyc(1);
    req = 4'b0100; cyc(3);
    req = 4'b0000; cyc(2);
    // Release/arrival collision.
    req = 4'b0010; cyc(3);
    req = 4'b1000; cyc(4);
    req = 4'b0000; cyc(2);
    // Constant contention: hold limit (when built) or indefinite hold.
    req = 4'b0011; cyc(25);
    req = 4'b0000; cyc(2);
    // Randomized traffic at several request churn rates.
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph == 0) ? 2 : (ph == 1) ? 4 : (ph == 2) ? 16 : 40;
      for (int c = 0; c < 500; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(rate - 1) == 0) req[b] = ~req[b];
        rst = ($urandom_range(199) == 0);
        cyc(1);
      end
    end
    rst = 1'b0; req = '0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
